// File: rtl/param_cordic.sv
// Iterative CORDIC rotator/vectorer, one micro-rotation per clock.
// Q3.(WIDTH-3) datapath with quadrant pre-rotation and optional 1/K scale.
module param_cordic #(
  parameter int WIDTH     = 32,
  parameter int ITER      = 16,
  parameter int GAIN_COMP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int FW = WIDTH - 3;
  localparam int CW = $clog2(WIDTH);
  localparam int TS = 1 << CW;

  localparam logic [31:0] HPI32 = 32'h3243F6A8;
  localparam logic signed [WIDTH-1:0] HPI =
    HPI32[31:32-WIDTH];
  localparam logic signed [WIDTH-1:0] NHPI = -HPI;

  localparam logic [63:0] KNUM =
    (64'd607252935 << FW) + 64'd500000000;
  localparam logic [63:0] KQ = KNUM / 64'd1000000000;
  localparam logic signed [WIDTH-1:0] KINV = KQ[WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE, RUN, SCALE, DONE
  } state_t;

  // atan(2^-i) in Q3.29; beyond i=9 it is 2^(29-i)-1 after truncation
  function automatic logic [31:0] atan_q29(input int i);
    case (i)
      0:       return 32'h1921FB54;
      1:       return 32'h0ED63382;
      2:       return 32'h07D6DD7E;
      3:       return 32'h03FAB753;
      4:       return 32'h01FF55BB;
      5:       return 32'h00FFEAAD;
      6:       return 32'h007FFD55;
      7:       return 32'h003FFFAA;
      8:       return 32'h001FFFF5;
      9:       return 32'h000FFFFE;
      default: return (i < 30) ?
        (32'd1 << (29 - i)) - 32'd1 : 32'd0;
    endcase
  endfunction

  logic signed [WIDTH-1:0] atan_tab [TS];

  for (genvar g = 0; g < TS; g++) begin : g_atan
    localparam logic [31:0] A = atan_q29(g);
    assign atan_tab[g] = A[31:32-WIDTH];
  end

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    mode_r;
  logic signed [WIDTH-1:0] xr, yr, zr;

  logic signed [WIDTH-1:0] px, py, pz;
  logic signed [WIDTH-1:0] xs, ys, at;
  logic signed [WIDTH-1:0] xn, yn, zn;
  logic signed [WIDTH-1:0] sx, sy;
  logic signed [2*WIDTH-1:0] mx, my;
  logic                    dir;

  // fold the input vector into the CORDIC convergence range
  always_comb begin
    px = x_in;
    py = y_in;
    pz = z_in;
    if (!mode) begin
      if (z_in > HPI) begin
        px = -y_in;
        py = x_in;
        pz = z_in - HPI;
      end else if (z_in < NHPI) begin
        px = y_in;
        py = -x_in;
        pz = z_in + HPI;
      end
    end else if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        px = y_in;
        py = -x_in;
        pz = z_in + HPI;
      end else begin
        px = -y_in;
        py = x_in;
        pz = z_in - HPI;
      end
    end
  end

  // one micro-rotation and the gain-compensation products
  always_comb begin
    dir = mode_r ? yr[WIDTH-1] : ~zr[WIDTH-1];
    xs  = xr >>> cnt;
    ys  = yr >>> cnt;
    at  = atan_tab[cnt];
    xn  = dir ? xr - ys : xr + ys;
    yn  = dir ? yr + xs : yr - xs;
    zn  = dir ? zr - at : zr + at;
    mx  = xr * KINV;
    my  = yr * KINV;
    sx  = mx[FW+WIDTH-1:FW];
    sy  = my[FW+WIDTH-1:FW];
  end

  // control FSM with registered busy/done and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            xr     <= px;
            yr     <= py;
            zr     <= pz;
            mode_r <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          xr  <= xn;
          yr  <= yn;
          zr  <= zn;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            if (GAIN_COMP != 0) begin
              state <= SCALE;
            end else begin
              x_out <= xn;
              y_out <= yn;
              z_out <= zn;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        SCALE: begin
          xr    <= sx;
          yr    <= sy;
          x_out <= sx;
          y_out <= sy;
          z_out <= zr;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_cordic.sv
// Scoreboard bench for param_cordic against a trig reference model.
// Random and directed rotation/vectoring jobs, handshake and reset cases.
module tb_param_cordic;

  localparam int  W    = 32;
  localparam int  IT   = 16;
  localparam int  GC   = 1;
  localparam int  LAT  = IT + 1 + GC;
  localparam real ONE  = 536870912.0;
  localparam real TOL  = 1e-4;
  localparam real PI   = 3.14159265358979;
  localparam longint ONEI = 64'd536870912;
  localparam longint ZLIM = 64'd1664299827;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic signed [W-1:0] z_in = '0;
  logic busy, done;
  logic signed [W-1:0] x_out, y_out, z_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    real   x;
    real   y;
    real   z;
    int    acc;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  param_cordic #(
    .WIDTH(W), .ITER(IT), .GAIN_COMP(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mode(mode), .x_in(x_in), .y_in(y_in),
    .z_in(z_in), .busy(busy), .done(done),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  function automatic real fx2r(input logic signed [W-1:0] v);
    return real'(v) / ONE;
  endfunction

  function automatic logic signed [W-1:0] r2fx(input real r);
    return W'(longint'(r * ONE));
  endfunction

  function automatic logic signed [W-1:0] rnd(input longint lim);
    longint v;
    v = longint'($urandom_range(32'(2 * lim), 0)) - lim;
    return W'(v);
  endfunction

  function automatic void chk_r(string tag, real act, real ex);
    checks++;
    if (act - ex > TOL || ex - act > TOL) begin
      failures++;
      $display("FAIL %s actual=%0.6f expected=%0.6f",
               tag, act, ex);
    end
  endfunction

  function automatic void chk_i(string tag, longint act,
                                longint ex);
    checks++;
    if (act != ex) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, ex);
    end
  endfunction

  // ideal rotation / vectoring result of the quantised inputs
  task automatic issue(input string tag,
                       input logic signed [W-1:0] x,
                       input logic signed [W-1:0] y,
                       input logic signed [W-1:0] z,
                       input logic m);
    real  xr, yr, zr;
    exp_t e;
    x_in  = x;
    y_in  = y;
    z_in  = z;
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    xr = fx2r(x);
    yr = fx2r(y);
    zr = fx2r(z);
    if (!m) begin
      e.x = xr * $cos(zr) - yr * $sin(zr);
      e.y = xr * $sin(zr) + yr * $cos(zr);
      e.z = 0.0;
    end else begin
      e.x = $sqrt(xr * xr + yr * yr);
      e.y = 0.0;
      e.z = zr + $atan2(yr, xr);
    end
    e.acc = cyc;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk);
      #1;
      if (done) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout actual=no_done expected=done", tag);
  endtask

  // monitor: every done pulse must match the oldest pending job
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          chk_i({e.tag, "_lat"}, cyc - e.acc + 1, LAT);
          chk_r({e.tag, "_x"}, fx2r(x_out), e.x);
          chk_r({e.tag, "_y"}, fx2r(y_out), e.y);
          chk_r({e.tag, "_z"}, fx2r(z_out), e.z);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [W-1:0] rx, ry, rz;

    repeat (3) @(posedge clk);
    #1;
    chk_i("rst_busy", busy, 0);
    chk_i("rst_done", done, 0);
    chk_i("rst_x", x_out, 0);
    chk_i("rst_y", y_out, 0);
    chk_i("rst_z", z_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    issue("rot1", r2fx(1.0), '0, r2fx(1.0), 1'b0);
    wait_done("rot1");
    @(negedge clk);
    issue("quad_p3", r2fx(1.0), '0, r2fx(3.0), 1'b0);
    wait_done("quad_p3");
    @(negedge clk);
    issue("quad_m3", r2fx(1.0), '0, r2fx(-3.0), 1'b0);
    wait_done("quad_m3");
    @(negedge clk);
    issue("vec135", r2fx(-0.5), r2fx(0.5), '0, 1'b1);
    wait_done("vec135");
    @(negedge clk);
    issue("vec180", r2fx(-0.5), '0, '0, 1'b1);
    wait_done("vec180");
    @(negedge clk);
    issue("rot_hpi", r2fx(0.8), r2fx(0.3),
          32'sh3243F6A8, 1'b0);
    wait_done("rot_hpi");
    @(negedge clk);
    issue("rot_hpi1", r2fx(0.8), r2fx(0.3),
          32'sh3243F6A9, 1'b0);
    wait_done("rot_hpi1");
    @(negedge clk);
    issue("rot_pi", r2fx(0.6), r2fx(-0.4), r2fx(PI), 1'b0);
    wait_done("rot_pi");
    @(negedge clk);
    issue("rot_mpi", r2fx(-1.0), r2fx(1.0), r2fx(-PI), 1'b0);
    wait_done("rot_mpi");

    @(negedge clk);
    issue("ign", r2fx(0.3), r2fx(-0.7), r2fx(-1.2), 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      x_in  = rnd(ONEI);
      y_in  = rnd(ONEI);
      z_in  = rnd(ZLIM);
      mode  = 1'($urandom_range(1, 0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("ign");

    @(negedge clk);
    issue("b2b_a", r2fx(0.9), r2fx(0.1), r2fx(0.5), 1'b0);
    wait_done("b2b_a");
    chk_i("b2b_busy_done", busy, 0);
    issue("b2b_b", r2fx(0.2), r2fx(-0.6), '0, 1'b1);
    chk_i("b2b_busy_run", busy, 1);
    wait_done("b2b_b");

    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n % 2 == 0) begin
        rx = rnd(ONEI);
        ry = rnd(ONEI);
        rz = rnd(ZLIM);
        issue("rnd_rot", rx, ry, rz, 1'b0);
      end else begin
        do begin
          rx = rnd(ONEI);
          ry = rnd(ONEI);
        end while (fx2r(rx) * fx2r(rx) +
                   fx2r(ry) * fx2r(ry) < 0.01);
        rz = rnd(ONEI / 2);
        issue("rnd_vec", rx, ry, rz, 1'b1);
      end
      wait_done("rnd");
    end

    @(negedge clk);
    issue("abort", r2fx(0.7), r2fx(0.7), r2fx(2.0), 1'b0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_i("arst_busy", busy, 0);
    chk_i("arst_done", done, 0);
    chk_i("arst_x", x_out, 0);
    chk_i("arst_y", y_out, 0);
    chk_i("arst_z", z_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", r2fx(-0.4), r2fx(0.9), r2fx(-2.5),
          1'b0);
    wait_done("post_rst");

    repeat (25) @(posedge clk);
    #1;
    chk_i("idle_busy", busy, 0);
    chk_i("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
